// File: rtl/in_unit.sv
// in_unit: signed decimal keypad entry unit.
// Collects up to three decimal digits plus a sign, then on ENTER checks the
// magnitude against the 8-bit two's complement range and either publishes the
// result on VALUE (with a VALUE_VALID pulse) or pulses ERR.
//
// Ports:
//   CLK          system clock, rising edge
//   RST          synchronous active-high reset
//   DIGIT        decimal digit, sampled while DIGIT_VALID=1
//   DIGIT_VALID  one-cycle strobe: a digit was entered
//   NEG_TOGGLE   one-cycle strobe: invert pending sign
//   ENTER        one-cycle strobe: commit pending entry
//   CLEAR        one-cycle strobe: discard pending entry
//   VALUE        last accepted result, two's complement
//   VALUE_VALID  one-cycle pulse: VALUE just updated
//   ERR          one-cycle pulse: entry out of range, rejected
//   HUNDREDS/TENS/ONES  BCD echo of pending digits
//   NEG          pending sign echo, 1 = negative
module in_unit (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] DIGIT,
    input  logic       DIGIT_VALID,
    input  logic       NEG_TOGGLE,
    input  logic       ENTER,
    input  logic       CLEAR,
    output logic [7:0] VALUE,
    output logic       VALUE_VALID,
    output logic       ERR,
    output logic [3:0] HUNDREDS,
    output logic [3:0] TENS,
    output logic [3:0] ONES,
    output logic       NEG
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t     state;
    logic [9:0] acc;
    logic [1:0] count;

    // Range check and negation are purely combinational on the held entry;
    // they are only consumed while in CHECK.
    logic       in_range;
    logic [7:0] result;

    always_comb begin
        in_range = NEG ? (acc <= 10'd128) : (acc <= 10'd127);
        // For acc=128 the low byte is 0x80 and its negation is 0x80 again;
        // for acc=0 the negation is 0x00.
        result   = NEG ? (~acc[7:0] + 8'd1) : acc[7:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            acc         <= '0;
            count       <= '0;
            VALUE       <= '0;
            VALUE_VALID <= 1'b0;
            ERR         <= 1'b0;
            HUNDREDS    <= '0;
            TENS        <= '0;
            ONES        <= '0;
            NEG         <= 1'b0;
        end else begin
            VALUE_VALID <= 1'b0;
            ERR         <= 1'b0;
            case (state)
                IDLE, ENTRY: begin
                    if (CLEAR) begin
                        state    <= IDLE;
                        acc      <= '0;
                        count    <= '0;
                        HUNDREDS <= '0;
                        TENS     <= '0;
                        ONES     <= '0;
                        NEG      <= 1'b0;
                    end else if (ENTER) begin
                        state <= CHECK;
                    end else if (NEG_TOGGLE) begin
                        NEG <= ~NEG;
                    end else if (DIGIT_VALID && (DIGIT <= 4'd9) && (count < 2'd3)) begin
                        HUNDREDS <= TENS;
                        TENS     <= ONES;
                        ONES     <= DIGIT;
                        // acc*10 + DIGIT, kept at 10 bits (max 999)
                        acc      <= (acc << 3) + (acc << 1) + {6'd0, DIGIT};
                        count    <= count + 2'd1;
                        state    <= ENTRY;
                    end
                end
                CHECK: begin
                    if (in_range) begin
                        VALUE       <= result;
                        VALUE_VALID <= 1'b1;
                    end else begin
                        ERR <= 1'b1;
                    end
                    state    <= IDLE;
                    acc      <= '0;
                    count    <= '0;
                    HUNDREDS <= '0;
                    TENS     <= '0;
                    ONES     <= '0;
                    NEG      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_in_unit.sv
// tb_in_unit: self-checking bench for in_unit.
// A behavioural model holds the pending entry as a list of decimal digits and
// a sign; every cycle the DUT outputs are compared against it, and a set of
// hand-computed literal expectations pins key results.
module tb_in_unit;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] DIGIT = '0;
    logic       DIGIT_VALID = 1'b0;
    logic       NEG_TOGGLE = 1'b0;
    logic       ENTER = 1'b0;
    logic       CLEAR = 1'b0;
    logic [7:0] VALUE;
    logic       VALUE_VALID;
    logic       ERR;
    logic [3:0] HUNDREDS;
    logic [3:0] TENS;
    logic [3:0] ONES;
    logic       NEG;

    in_unit dut (
        .CLK(CLK), .RST(RST), .DIGIT(DIGIT), .DIGIT_VALID(DIGIT_VALID),
        .NEG_TOGGLE(NEG_TOGGLE), .ENTER(ENTER), .CLEAR(CLEAR),
        .VALUE(VALUE), .VALUE_VALID(VALUE_VALID), .ERR(ERR),
        .HUNDREDS(HUNDREDS), .TENS(TENS), .ONES(ONES), .NEG(NEG)
    );

    always #5 CLK = ~CLK;

    // Behavioural model state
    int   digits[$];
    bit   m_neg;
    bit   m_check;
    logic [7:0] e_value;
    bit   e_vv;
    bit   e_err;

    int vectors = 0;
    int miscompares = 0;

    function automatic int held_value();
        int mag = 0;
        foreach (digits[i]) mag = mag * 10 + digits[i];
        return mag;
    endfunction

    function automatic logic [3:0] echo(int pos);
        int n = digits.size();
        if (n > pos) return 4'(digits[n - 1 - pos]);
        return 4'd0;
    endfunction

    task automatic model_edge(bit r, bit dv, logic [3:0] d, bit ng, bit ent, bit clr);
        int mag;
        int res;
        e_vv  = 0;
        e_err = 0;
        if (r) begin
            digits.delete();
            m_neg = 0; m_check = 0; e_value = 8'h00;
        end else if (m_check) begin
            mag = held_value();
            if (mag <= (m_neg ? 128 : 127)) begin
                res = m_neg ? -mag : mag;
                e_value = res[7:0];
                e_vv = 1;
            end else begin
                e_err = 1;
            end
            digits.delete();
            m_neg = 0; m_check = 0;
        end else if (clr) begin
            digits.delete();
            m_neg = 0;
        end else if (ent) begin
            m_check = 1;
        end else if (ng) begin
            m_neg = ~m_neg;
        end else if (dv && d <= 9 && digits.size() < 3) begin
            digits.push_back(int'(d));
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare #1 later.
    task automatic step(bit r, bit dv, logic [3:0] d, bit ng, bit ent, bit clr);
        logic [24:0] act, exp;
        RST = r; DIGIT_VALID = dv; DIGIT = d; NEG_TOGGLE = ng; ENTER = ent; CLEAR = clr;
        @(posedge CLK);
        model_edge(r, dv, d, ng, ent, clr);
        #1;
        act = {VALUE, VALUE_VALID, ERR, HUNDREDS, TENS, ONES, NEG};
        exp = {e_value, e_vv, e_err, echo(2), echo(1), echo(0), m_neg};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL cycle_model t=%0t got V=%h vv=%b err=%b H/T/O=%0d/%0d/%0d neg=%b want V=%h vv=%b err=%b H/T/O=%0d/%0d/%0d neg=%b",
                     $time, VALUE, VALUE_VALID, ERR, HUNDREDS, TENS, ONES, NEG,
                     e_value, e_vv, e_err, echo(2), echo(1), echo(0), m_neg);
        end
        if (VALUE_VALID && ERR) begin
            miscompares++;
            $display("FAIL pulse_exclusive t=%0t got vv=1 err=1 want not both", $time);
        end
    endtask

    task automatic lit(string name, logic [15:0] act, logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle();        step(0, 0, 4'd0, 0, 0, 0); endtask
    task automatic dig(int v);    step(0, 1, 4'(v), 0, 0, 0); endtask
    task automatic neg_t();       step(0, 0, 4'd0, 1, 0, 0); endtask
    task automatic enter();       step(0, 0, 4'd0, 0, 1, 0); endtask

    initial begin
        m_neg = 0; m_check = 0; e_value = 8'h00; e_vv = 0; e_err = 0;

        // Reset
        step(1, 0, 4'd0, 0, 0, 0);
        step(1, 1, 4'd5, 1, 1, 1);
        lit("reset_value", {8'h0, VALUE}, 16'h0000);
        lit("reset_flags", {10'h0, VALUE_VALID, ERR, NEG, 3'b0}, 16'h0000);
        idle();

        // 1,2,7 -> 0x7F
        dig(1); dig(2); dig(7);
        lit("echo_127", {4'h0, HUNDREDS, TENS, ONES}, 16'h0127);
        enter();
        lit("check_no_pulse", {14'h0, VALUE_VALID, ERR}, 16'h0000);
        idle();
        lit("val_7f", {7'h0, VALUE_VALID, VALUE}, 16'h017F);
        idle();
        lit("vv_one_cycle", {15'h0, VALUE_VALID}, 16'h0000);

        // -128 accepted, +128 rejected
        neg_t(); dig(1); dig(2); dig(8); enter(); idle();
        lit("val_m128", {7'h0, VALUE_VALID, VALUE}, 16'h0180);
        dig(1); dig(2); dig(8); enter(); idle();
        lit("err_p128", {7'h0, ERR, VALUE}, 16'h0180);

        // 4th digit ignored, 599 rejected, digit 0xC ignored
        dig(5); dig(9); dig(9); dig(3);
        lit("echo_599", {4'h0, HUNDREDS, TENS, ONES}, 16'h0599);
        enter(); idle();
        lit("err_599", {15'h0, ERR}, 16'h0001);
        dig(12);
        lit("bad_digit", {11'h0, ERR, ONES}, 16'h0000);

        // -0 -> 0x00; double toggle then 42
        neg_t(); enter(); idle();
        lit("val_m0", {7'h0, VALUE_VALID, VALUE}, 16'h0100);
        neg_t(); neg_t(); dig(4); dig(2); enter(); idle();
        lit("val_42", {7'h0, VALUE_VALID, VALUE}, 16'h012A);

        // CLEAR beats ENTER; ENTER beats NEG_TOGGLE/DIGIT_VALID; CHECK ignores strobes
        dig(3); dig(3); step(0, 0, 4'd0, 0, 1, 1); idle();
        lit("clear_wins", {6'h0, VALUE_VALID, ERR, TENS, ONES}, 16'h0000);
        dig(5); step(0, 1, 4'd6, 1, 1, 0); step(0, 1, 4'd7, 1, 0, 0);
        lit("enter_wins", {7'h0, VALUE_VALID, VALUE}, 16'h0105);

        // Reset during CHECK
        dig(9); enter(); step(1, 0, 4'd0, 0, 0, 0);
        lit("rst_in_check", {6'h0, VALUE_VALID, ERR, VALUE}, 16'h0000);
        idle();
        lit("rst_no_late_pulse", {14'h0, VALUE_VALID, ERR}, 16'h0000);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, dv, ng, ent, clr;
            logic [3:0] d;
            r   = ($urandom_range(0, 99) == 0);
            clr = ($urandom_range(0, 19) == 0);
            ent = ($urandom_range(0, 7) == 0);
            ng  = ($urandom_range(0, 9) == 0);
            dv  = ($urandom_range(0, 1) == 1);
            d   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
            step(r, dv, d, ng, ent, clr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
